// File: rtl/opendap_swd_host.sv
`default_nettype none
// ============================================================================
//  Module      : opendap_swd_host
//  Description : SWD host serial engine. Executes one command at a time
//                (DP/AP transfer, line reset, idle clocks, no-op), generates
//                SWCLK from clk, serialises header/write data and samples
//                ACK/read data/parity from the target SW-DP.
//  Revision    : 1.0 - initial release
// ============================================================================
module opendap_swd_host #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] clkdiv,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_ap_ndp,
    input  logic             cmd_r_nw,
    input  logic [1:0]       cmd_addr,
    input  logic [31:0]      cmd_wdata,
    output logic             rsp_valid,
    output logic [2:0]       rsp_ack,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_parity_err,
    output logic             swclk,
    output logic             swdo,
    output logic             swdo_en,
    input  logic             swdi
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_HDR     = 4'd1;
    localparam logic [3:0] S_TRN1    = 4'd2;
    localparam logic [3:0] S_ACK     = 4'd3;
    localparam logic [3:0] S_RDATA   = 4'd4;
    localparam logic [3:0] S_TRN2    = 4'd5;
    localparam logic [3:0] S_WDATA   = 4'd6;
    localparam logic [3:0] S_LRST    = 4'd7;
    localparam logic [3:0] S_IDLECLK = 4'd8;

    localparam logic [1:0] OP_XFER = 2'b00;
    localparam logic [1:0] OP_LRST = 2'b01;
    localparam logic [1:0] OP_IDLE = 2'b10;

    logic [3:0]       state;
    logic [DIV_W-1:0] div;        // divider latched at accept
    logic [DIV_W-1:0] phase_cnt;  // clk cycles elapsed in current SWCLK phase
    logic [5:0]       bit_cnt;    // bit index within current state
    logic [31:0]      shreg;      // write data out / read data in / idle count
    logic             par;        // running parity (read check or write parity)
    logic [2:0]       ack;
    logic             ap_ndp;
    logic             r_nw;
    logic [1:0]       addr;

    logic [7:0]       hdr;
    logic             phase_end;
    logic             rise;
    logic             fall;
    logic             ack_ok;
    logic             last_bit;
    logic             done;
    logic             imm_done;

    // Request header, bit 0 goes on the wire first: start, APnDP, RnW, A2, A3,
    // parity, stop, park.
    assign hdr = {1'b1, 1'b0, ap_ndp ^ r_nw ^ addr[0] ^ addr[1],
                  addr[1], addr[0], r_nw, ap_ndp, 1'b1};

    assign phase_end = (state != S_IDLE) && (phase_cnt == div);
    assign rise      = phase_end && !swclk;   // end of low phase: sample swdi
    assign fall      = phase_end &&  swclk;   // end of high phase: next bit
    assign ack_ok    = (ack == 3'b001);
    assign cmd_ready = (state == S_IDLE);
    assign done      = fall && last_bit;

    // Commands that finish without producing any SWCLK cycle.
    assign imm_done  = (cmd_op == 2'b11) ||
                       ((cmd_op == OP_IDLE) && (cmd_wdata[7:0] == 8'd0));

    // Decide whether the bit currently on the wire is the final one of the command.
    always_comb begin
        last_bit = 1'b0;
        case (state)
            S_TRN2:    last_bit = !(ack_ok && !r_nw);
            S_WDATA:   last_bit = (bit_cnt == 6'd32);
            S_LRST:    last_bit = (bit_cnt == 6'd51);
            S_IDLECLK: last_bit = (shreg[7:0] == 8'd1);
            default:   last_bit = 1'b0;
        endcase
    end

    // Main sequencer: command accept, SWCLK phase timing, bit shifting and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            div            <= '0;
            phase_cnt      <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            par            <= 1'b0;
            ack            <= '0;
            ap_ndp         <= 1'b0;
            r_nw           <= 1'b0;
            addr           <= '0;
            swclk          <= 1'b0;
            swdo           <= 1'b0;
            swdo_en        <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_ack        <= '0;
            rsp_rdata      <= '0;
            rsp_parity_err <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == S_IDLE) begin
                if (cmd_valid) begin
                    div       <= clkdiv;
                    phase_cnt <= '0;
                    swclk     <= 1'b0;
                    bit_cnt   <= '0;
                    ap_ndp    <= cmd_ap_ndp;
                    r_nw      <= cmd_r_nw;
                    addr      <= cmd_addr;
                    shreg     <= cmd_wdata;
                    par       <= 1'b0;
                    ack       <= '0;
                    swdo_en   <= 1'b1;
                    swdo      <= 1'b0;
                    if (imm_done) begin
                        rsp_valid      <= 1'b1;
                        rsp_ack        <= '0;
                        rsp_rdata      <= '0;
                        rsp_parity_err <= 1'b0;
                    end else if (cmd_op == OP_XFER) begin
                        state <= S_HDR;
                        swdo  <= 1'b1;   // start bit
                    end else if (cmd_op == OP_LRST) begin
                        state <= S_LRST;
                        swdo  <= 1'b1;
                    end else begin
                        state <= S_IDLECLK;
                    end
                end
            end else begin
                if (phase_end) begin
                    phase_cnt <= '0;
                    swclk     <= !swclk;
                end else begin
                    phase_cnt <= phase_cnt + DIV_W'(1);
                end

                if (rise) begin
                    case (state)
                        S_ACK: ack[bit_cnt[1:0]] <= swdi;
                        S_RDATA: begin
                            // Data bits shift in LSB first; parity bit only
                            // folds into the running check.
                            if (bit_cnt < 6'd32) begin
                                shreg <= {swdi, shreg[31:1]};
                            end
                            par <= par ^ swdi;
                        end
                        default: ;
                    endcase
                end

                if (done) begin
                    state          <= S_IDLE;
                    swdo_en        <= 1'b1;
                    swdo           <= 1'b0;
                    rsp_valid      <= 1'b1;
                    rsp_ack        <= ((state == S_TRN2) || (state == S_WDATA)) ? ack : 3'b000;
                    rsp_rdata      <= ((state == S_TRN2) && ack_ok && r_nw) ? shreg : 32'd0;
                    rsp_parity_err <= (state == S_TRN2) && ack_ok && r_nw && par;
                end else if (fall) begin
                    case (state)
                        S_HDR: begin
                            if (bit_cnt == 6'd7) begin
                                state   <= S_TRN1;
                                bit_cnt <= '0;
                                swdo_en <= 1'b0;
                                swdo    <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                                swdo    <= hdr[bit_cnt[2:0] + 3'd1];
                            end
                        end
                        S_TRN1: begin
                            state   <= S_ACK;
                            bit_cnt <= '0;
                        end
                        S_ACK: begin
                            if (bit_cnt == 6'd2) begin
                                bit_cnt <= '0;
                                if (ack_ok && r_nw) begin
                                    state <= S_RDATA;
                                    shreg <= '0;
                                    par   <= 1'b0;
                                end else begin
                                    state <= S_TRN2;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                        S_RDATA: begin
                            if (bit_cnt == 6'd32) begin
                                state <= S_TRN2;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                        S_TRN2: begin
                            // Only an OK write gets here without completing.
                            state   <= S_WDATA;
                            bit_cnt <= '0;
                            swdo_en <= 1'b1;
                            swdo    <= shreg[0];
                            par     <= ^shreg;
                        end
                        S_WDATA: begin
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd31) begin
                                swdo <= par;
                            end else begin
                                swdo  <= shreg[1];
                                shreg <= {1'b0, shreg[31:1]};
                            end
                        end
                        S_LRST: bit_cnt <= bit_cnt + 6'd1;
                        S_IDLECLK: shreg[7:0] <= shreg[7:0] - 8'd1;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_opendap_swd_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_opendap_swd_host
//  Description : Self-checking bench for opendap_swd_host with a target model
//                answering on swdi and a wire-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_opendap_swd_host;

    localparam int DIV_W  = 8;
    localparam int BUDGET = 4000;
    localparam int MSZ    = 8192;

    logic             clk;
    logic             rst_n;
    logic [DIV_W-1:0] clkdiv;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_ap_ndp;
    logic             cmd_r_nw;
    logic [1:0]       cmd_addr;
    logic [31:0]      cmd_wdata;
    logic             rsp_valid;
    logic [2:0]       rsp_ack;
    logic [31:0]      rsp_rdata;
    logic             rsp_parity_err;
    logic             swclk;
    logic             swdo;
    logic             swdo_en;
    logic             swdi;

    opendap_swd_host #(.DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .clkdiv(clkdiv),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ap_ndp(cmd_ap_ndp), .cmd_r_nw(cmd_r_nw), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .rsp_rdata(rsp_rdata), .rsp_parity_err(rsp_parity_err),
        .swclk(swclk), .swdo(swdo), .swdo_en(swdo_en), .swdi(swdi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        ap;
        logic        rnw;
        logic [1:0]  addr;
        logic [31:0] wdata;
        int          d;
        logic [2:0]  tack;
        logic [31:0] tdata;
        logic        flip;
        logic [7:0]  e_hdr;
        logic [2:0]  e_ack;
        logic [31:0] e_rdata;
        logic        e_perr;
        int          e_bits;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Wire monitor: every SWCLK rising edge is logged; the target answers
    // on swdi with the bit scheduled for the next SWCLK cycle.
    int   total_rises = 0;
    int   base = 0;
    logic mon_do[MSZ];
    logic mon_en[MSZ];
    logic tgt_line[64];
    logic prev_swclk = 1'b0;

    always @(posedge clk) begin
        int k;
        #1;
        if (swclk && !prev_swclk) begin
            mon_do[total_rises % MSZ] = swdo;
            mon_en[total_rises % MSZ] = swdo_en;
            total_rises++;
        end
        prev_swclk = swclk;
        k = total_rises - base;
        swdi = (k >= 0 && k < 64) ? tgt_line[k] : 1'b0;
    end

    // Expected wire contents built from the protocol framing.
    logic exp_do[64];
    logic exp_en[64];
    int   exp_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hdr_of(input vec_t v);
        return {1'b1, 1'b0, v.ap ^ v.rnw ^ v.addr[0] ^ v.addr[1],
                v.addr[1], v.addr[0], v.rnw, v.ap, 1'b1};
    endfunction

    function automatic void push(input logic val, input logic en);
        if (exp_n < 64) begin
            exp_do[exp_n] = val;
            exp_en[exp_n] = en;
        end
        exp_n++;
    endfunction

    function automatic void model_wire(input vec_t v);
        logic [7:0] h;
        h = hdr_of(v);
        exp_n = 0;
        case (v.op)
            2'b00: begin
                for (int i = 0; i < 8; i++) push(h[i], 1'b1);
                for (int i = 0; i < 4; i++) push(1'b0, 1'b0);        // turnaround + ACK
                if (v.tack == 3'b001 && v.rnw) begin
                    for (int i = 0; i < 34; i++) push(1'b0, 1'b0);   // data, parity, turnaround
                end else if (v.tack == 3'b001) begin
                    push(1'b0, 1'b0);
                    for (int i = 0; i < 32; i++) push(v.wdata[i], 1'b1);
                    push(^v.wdata, 1'b1);
                end else begin
                    push(1'b0, 1'b0);
                end
            end
            2'b01: for (int i = 0; i < 52; i++) push(1'b1, 1'b1);
            2'b10: for (int i = 0; i < int'(v.wdata[7:0]); i++) push(1'b0, 1'b1);
            default: ;
        endcase
    endfunction

    function automatic vec_t make_exp(input vec_t v);
        vec_t r;
        logic ok_rd;
        r       = v;
        ok_rd   = (v.op == 2'b00) && (v.tack == 3'b001) && v.rnw;
        r.e_hdr = hdr_of(v);
        r.e_ack = (v.op == 2'b00) ? v.tack : 3'b000;
        r.e_rdata = ok_rd ? v.tdata : 32'd0;
        r.e_perr  = ok_rd && v.flip;
        model_wire(v);
        r.e_bits  = exp_n;
        return r;
    endfunction

    task automatic load_target(input vec_t v);
        for (int i = 0; i < 64; i++) tgt_line[i] = 1'($urandom_range(0, 1));
        if (v.op == 2'b00) begin
            for (int i = 0; i < 3; i++) tgt_line[9 + i] = v.tack[i];
            if (v.tack == 3'b001 && v.rnw) begin
                for (int i = 0; i < 32; i++) tgt_line[12 + i] = v.tdata[i];
                tgt_line[44] = (^v.tdata) ^ v.flip;
            end
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        clkdiv     = DIV_W'(v.d);
        cmd_op     = v.op;
        cmd_ap_ndp = v.ap;
        cmd_r_nw   = v.rnw;
        cmd_addr   = v.addr;
        cmd_wdata  = v.wdata;
        cmd_valid  = 1'b1;
    endtask

    // One full command: accept, wait for completion, compare response and wire.
    task automatic do_cmd(input vec_t v, input string name);
        int   lat;
        bit   got;
        int   nb;
        int   bad;
        logic [7:0] h;
        load_target(v);
        model_wire(v);
        drive_cmd(v);
        chk({name, ".ready"}, 64'(cmd_ready), 64'd1);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        base      = total_rises;
        clkdiv    = DIV_W'($urandom_range(0, 255));
        lat = 0;
        got = 1'b0;
        while (!got && lat < BUDGET) begin
            if (rsp_valid) got = 1'b1;
            else begin
                @(posedge clk); #2;
                lat++;
            end
        end
        chk({name, ".done"}, 64'(got), 64'd1);
        chk({name, ".latency"}, 64'(lat), 64'(2 * (v.d + 1) * v.e_bits));
        chk({name, ".ack"}, 64'(rsp_ack), 64'(v.e_ack));
        chk({name, ".rdata"}, 64'(rsp_rdata), 64'(v.e_rdata));
        chk({name, ".perr"}, 64'(rsp_parity_err), 64'(v.e_perr));
        nb = total_rises - base;
        chk({name, ".swclk_edges"}, 64'(nb), 64'(v.e_bits));
        if (v.op == 2'b00) begin
            for (int i = 0; i < 8; i++) h[i] = mon_do[(base + i) % MSZ];
            chk({name, ".hdr"}, 64'(h), 64'(v.e_hdr));
        end
        bad = 0;
        for (int i = 0; i < exp_n && i < 64; i++) begin
            if (mon_en[(base + i) % MSZ] !== exp_en[i]) bad++;
            else if (exp_en[i] && (mon_do[(base + i) % MSZ] !== exp_do[i])) bad++;
        end
        chk({name, ".wire_bits_wrong"}, 64'(bad), 64'd0);
        @(posedge clk); #2;
        chk({name, ".pulse"}, 64'(rsp_valid), 64'd0);
    endtask

    vec_t vecs[8];

    initial begin
        vec_t v;
        int   r;
        int   t;
        int   p1;
        int   p2;
        int   bad;
        int   n;

        rst_n = 1'b0; cmd_valid = 1'b0; clkdiv = '0; cmd_op = '0;
        cmd_ap_ndp = 1'b0; cmd_r_nw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        for (int i = 0; i < 64; i++) tgt_line[i] = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("reset.outputs",
            64'({cmd_ready, rsp_valid, rsp_ack, rsp_parity_err, swclk, swdo, swdo_en}),
            64'(9'b1_0_000_0_0_0_0));
        chk("reset.rdata", 64'(rsp_rdata), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        //        op    ap   rnw  addr  wdata          d tack    tdata          flip hdr    e_ack   e_rdata        perr bits
        vecs[0] = '{2'b00, 1'b0, 1'b1, 2'd0, 32'h0,        0, 3'b001, 32'h2BA01477, 1'b0, 8'hA5, 3'b001, 32'h2BA01477, 1'b0, 46};
        vecs[1] = '{2'b00, 1'b0, 1'b0, 2'd1, 32'h50000000, 0, 3'b001, 32'h0,        1'b0, 8'hA9, 3'b001, 32'h0,        1'b0, 46};
        vecs[2] = '{2'b00, 1'b0, 1'b1, 2'd0, 32'h0,        0, 3'b010, 32'hFFFFFFFF, 1'b0, 8'hA5, 3'b010, 32'h0,        1'b0, 13};
        vecs[3] = '{2'b00, 1'b0, 1'b1, 2'd0, 32'h0,        0, 3'b100, 32'hFFFFFFFF, 1'b0, 8'hA5, 3'b100, 32'h0,        1'b0, 13};
        vecs[4] = '{2'b00, 1'b0, 1'b1, 2'd0, 32'h0,        1, 3'b001, 32'h00000001, 1'b1, 8'hA5, 3'b001, 32'h00000001, 1'b1, 46};
        vecs[5] = '{2'b01, 1'b0, 1'b0, 2'd0, 32'h0,        0, 3'b000, 32'h0,        1'b0, 8'h00, 3'b000, 32'h0,        1'b0, 52};
        vecs[6] = '{2'b10, 1'b0, 1'b0, 2'd0, 32'h3,        2, 3'b000, 32'h0,        1'b0, 8'h00, 3'b000, 32'h0,        1'b0, 3};
        vecs[7] = '{2'b11, 1'b1, 1'b1, 2'd3, 32'hFFFFFFFF, 0, 3'b001, 32'h0,        1'b0, 8'h00, 3'b000, 32'h0,        1'b0, 0};
        for (int i = 0; i < 8; i++) do_cmd(vecs[i], $sformatf("vec%0d", i));

        // Line reset followed back-to-back by 2 idle clocks.
        v = '{2'b01, 1'b0, 1'b0, 2'd0, 32'h0, 0, 3'b000, 32'h0, 1'b0, 8'h00, 3'b000, 32'h0, 1'b0, 52};
        drive_cmd(v);
        @(posedge clk); #2;
        base      = total_rises;
        cmd_op    = 2'b10;
        cmd_wdata = 32'h2;
        t = 0; p1 = -1; p2 = -1;
        while (t < 500 && p2 < 0) begin
            @(posedge clk); #2;
            t++;
            if (p1 >= 0 && t == p1 + 1) cmd_valid = 1'b0;
            if (rsp_valid) begin
                if (p1 < 0) p1 = t;
                else p2 = t;
            end
        end
        cmd_valid = 1'b0;
        chk("b2b.first_done", 64'(p1), 64'd104);
        chk("b2b.second_done", 64'(p2), 64'd109);
        chk("b2b.edges", 64'(total_rises - base), 64'd54);
        bad = 0;
        for (int i = 0; i < 54; i++) begin
            if (mon_en[(base + i) % MSZ] !== 1'b1) bad++;
            if (mon_do[(base + i) % MSZ] !== (i < 52 ? 1'b1 : 1'b0)) bad++;
        end
        chk("b2b.wire_bits_wrong", 64'(bad), 64'd0);
        chk("b2b.ack", 64'(rsp_ack), 64'd0);
        @(posedge clk); #2;

        // Divider phase lengths, then asynchronous reset inside the ACK phase.
        v = make_exp('{2'b00, 1'b0, 1'b1, 2'd0, 32'h0, 3, 3'b001, 32'h12345678, 1'b0,
                       8'h00, 3'b000, 32'h0, 1'b0, 0});
        load_target(v);
        drive_cmd(v);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        base = total_rises;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (swclk !== 1'(((i / 4) % 2))) bad++;
            @(posedge clk); #2;
        end
        chk("div3.phase_len_wrong", 64'(bad), 64'd0);
        n = 0;
        while ((total_rises - base) < 10 && n < 1000) begin
            @(posedge clk); #2;
            n++;
        end
        chk("rst.reached_ack", 64'(total_rises - base), 64'd10);
        #1 rst_n = 1'b0;
        #1;
        chk("rst.async_outputs",
            64'({cmd_ready, rsp_valid, rsp_ack, rsp_parity_err, swclk, swdo, swdo_en}),
            64'(9'b1_0_000_0_0_0_0));
        chk("rst.async_rdata", 64'(rsp_rdata), 64'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            if (rsp_valid !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (rsp_valid !== 1'b0) bad++;
        end
        chk("rst.no_rsp", 64'(bad), 64'd0);
        do_cmd(vecs[0], "post_reset_read");

        // Randomized commands against the reference model.
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            v.op    = (r < 6 || r == 9) ? 2'b00 : (r == 6) ? 2'b01 : (r == 7) ? 2'b10 : 2'b11;
            v.ap    = 1'($urandom_range(0, 1));
            v.rnw   = 1'($urandom_range(0, 1));
            v.addr  = 2'($urandom_range(0, 3));
            v.wdata = $urandom;
            if (v.op == 2'b10) v.wdata[7:0] = 8'($urandom_range(0, 6));
            v.d     = $urandom_range(0, 3);
            case ($urandom_range(0, 5))
                0, 1, 2: v.tack = 3'b001;
                3:       v.tack = 3'b010;
                4:       v.tack = 3'b100;
                default: v.tack = 3'($urandom_range(0, 7));
            endcase
            v.tdata = $urandom;
            v.flip  = 1'($urandom_range(0, 1));
            v = make_exp(v);
            do_cmd(v, $sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
